// File: rtl/hiscore_upload_pkg.sv
// Shared definitions for the hiscore upload path: FSM states, fill byte, timeout counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hiscore_upload_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PAUSE   = 3'd1,
        READY   = 3'd2,
        FETCH   = 3'd3,
        CAPTURE = 3'd4
    } state_t;

    localparam logic [7:0] FILL_BYTE = 8'hFF;
    localparam int         CNT_W     = 16;

endpackage

// File: rtl/hiscore_upload.sv
// Serves HPS byte reads from the hiscore RAM while the game CPU is paused.
// Latency: ioctl_rd in cycle N -> ioctl_din valid, ioctl_wait low from N+3.
// Backpressure: ioctl_wait holds the HPS off; early reads park in a one-deep pending slot.
module hiscore_upload
    import hiscore_upload_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int UP_SIZE     = 1024,
    parameter int ACK_TIMEOUT = 65535
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              pause_req,
    input  logic              pause_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_q,
    output logic              ack_timeout
);

    localparam logic [24:0]      UP_LIM  = 25'(UP_SIZE);
    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(ACK_TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             pend_vld;
    logic [24:0]      pend_addr;
    logic             rd_hit;
    logic [24:0]      sel_addr;
    logic             sel_hit;

    // A fresh request in READY wins over a parked one.
    always_comb begin
        sel_addr = ioctl_rd ? ioctl_addr : pend_addr;
        sel_hit  = (sel_addr < UP_LIM);
        cnt_nxt  = (tmo_cnt == {CNT_W{1'b1}}) ? tmo_cnt : tmo_cnt + 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= IDLE;
            ioctl_din   <= 8'h00;
            ioctl_wait  <= 1'b0;
            pause_req   <= 1'b0;
            ram_rd      <= 1'b0;
            ram_addr    <= '0;
            ack_timeout <= 1'b0;
            tmo_cnt     <= '0;
            pend_vld    <= 1'b0;
            pend_addr   <= '0;
            rd_hit      <= 1'b0;
        end else if (state != IDLE && !ioctl_upload) begin
            state      <= IDLE;
            pause_req  <= 1'b0;
            ram_rd     <= 1'b0;
            ioctl_wait <= 1'b0;
            pend_vld   <= 1'b0;
        end else begin
            if (ioctl_rd && ioctl_upload && state != READY) begin
                pend_vld  <= 1'b1;
                pend_addr <= ioctl_addr;
            end
            case (state)
                IDLE: begin
                    if (ioctl_upload) begin
                        state       <= PAUSE;
                        pause_req   <= 1'b1;
                        ioctl_wait  <= 1'b1;
                        ack_timeout <= 1'b0;
                        tmo_cnt     <= '0;
                    end
                end
                PAUSE: begin
                    tmo_cnt <= cnt_nxt;
                    if (pause_ack) begin
                        state      <= READY;
                        ioctl_wait <= 1'b0;
                    end else if (cnt_nxt >= TMO_LIM) begin
                        state       <= READY;
                        ioctl_wait  <= 1'b0;
                        ack_timeout <= 1'b1;
                    end
                end
                READY: begin
                    if (ioctl_rd || pend_vld) begin
                        state      <= FETCH;
                        ioctl_wait <= 1'b1;
                        pend_vld   <= 1'b0;
                        rd_hit     <= sel_hit;
                        if (sel_hit) begin
                            ram_rd   <= 1'b1;
                            ram_addr <= sel_addr[ADDR_W-1:0];
                        end
                    end
                end
                FETCH: begin
                    ram_rd <= 1'b0;
                    state  <= CAPTURE;
                end
                CAPTURE: begin
                    ioctl_din  <= rd_hit ? ram_q : FILL_BYTE;
                    ioctl_wait <= 1'b0;
                    state      <= READY;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hiscore_upload.sv
// Bench for hiscore_upload: table of reads plus hand-built pause/pending/abort/reset sequences.
// Latency: n/a. Backpressure: n/a.
// Expected bytes are queued when a read is issued and popped when ioctl_wait drops.
module tb_hiscore_upload;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        pause_req;
    logic        pause_ack;
    logic [9:0]  ram_addr;
    logic        ram_rd;
    logic [7:0]  ram_q;
    logic        ack_timeout;

    hiscore_upload #(.ADDR_W(10), .UP_SIZE(1024), .ACK_TIMEOUT(16)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ioctl_upload (ioctl_upload),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .ioctl_wait   (ioctl_wait),
        .pause_req    (pause_req),
        .pause_ack    (pause_ack),
        .ram_addr     (ram_addr),
        .ram_rd       (ram_rd),
        .ram_q        (ram_q),
        .ack_timeout  (ack_timeout)
    );

    always #5 clk_sys = ~clk_sys;

    // RAM contents: byte = addr[7:0] ^ 8'hC3, except RAM[3] = 8'h5A.
    logic [7:0] mem [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'hC3;
        mem[3] = 8'h5A;
    end
    always @(posedge clk_sys) if (ram_rd) ram_q <= mem[ram_addr];

    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0;
    int exp_pulses = 0;
    logic [7:0] exp_q [$];
    logic [7:0] last_din;

    always @(posedge clk_sys) if (!reset && ram_rd) pulses++;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  din;
        logic        hit;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " din"},         32'(ioctl_din),   32'h00);
        check({tag, " wait"},        32'(ioctl_wait),  32'd0);
        check({tag, " pause_req"},   32'(pause_req),   32'd0);
        check({tag, " ram_rd"},      32'(ram_rd),      32'd0);
        check({tag, " ram_addr"},    32'(ram_addr),    32'd0);
        check({tag, " ack_timeout"}, 32'(ack_timeout), 32'd0);
    endtask

    // Called at a negedge while the DUT sits in READY.
    task automatic do_read(input logic [24:0] a, input logic [7:0] ed, input logic eh, input string tag);
        logic [7:0] want;
        exp_q.push_back(ed);
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        check({tag, " ram_rd N+1"}, 32'(ram_rd), 32'(eh));
        check({tag, " wait N+1"},   32'(ioctl_wait), 32'd1);
        if (eh) check({tag, " ram_addr"}, 32'(ram_addr), 32'(a[9:0]));
        @(negedge clk_sys);
        check({tag, " ram_rd N+2"}, 32'(ram_rd), 32'd0);
        check({tag, " wait N+2"},   32'(ioctl_wait), 32'd1);
        @(negedge clk_sys);
        check({tag, " wait N+3"},   32'(ioctl_wait), 32'd0);
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        check({tag, " din N+3"},    32'(ioctl_din), 32'(want));
        if (eh) exp_pulses++;
        last_din = ed;
    endtask

    task automatic abort_session(input string tag);
        ioctl_upload = 1'b0;
        @(negedge clk_sys);
        check({tag, " pause_req"}, 32'(pause_req),  32'd0);
        check({tag, " wait"},      32'(ioctl_wait), 32'd0);
        check({tag, " ram_rd"},    32'(ram_rd),     32'd0);
        check({tag, " din hold"},  32'(ioctl_din),  32'(last_din));
    endtask

    initial begin
        int cnt;
        vecs[0] = '{25'h003,     8'h5A, 1'b1};
        vecs[1] = '{25'h400,     8'hFF, 1'b0};
        vecs[2] = '{25'h000,     8'hC3, 1'b1};
        vecs[3] = '{25'h3FF,     8'h3C, 1'b1};
        vecs[4] = '{25'h123,     8'hE0, 1'b1};
        vecs[5] = '{25'h1FFFFFF, 8'hFF, 1'b0};
        vecs[6] = '{25'h3FE,     8'h3D, 1'b1};

        reset = 1'b1; ioctl_upload = 1'b0; ioctl_rd = 1'b0; ioctl_addr = '0; pause_ack = 1'b0;
        last_din = 8'h00;
        repeat (3) @(negedge clk_sys);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk_sys);
        check_reset_vals("idle");

        // Session start, ack after 5 cycles.
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        check("start pause_req", 32'(pause_req), 32'd1);
        check("start wait", 32'(ioctl_wait), 32'd1);
        repeat (4) @(negedge clk_sys);
        check("paused wait", 32'(ioctl_wait), 32'd1);
        pause_ack = 1'b1;
        @(negedge clk_sys);
        check("ready wait", 32'(ioctl_wait), 32'd0);
        check("ready ack_timeout", 32'(ack_timeout), 32'd0);

        for (int i = 0; i < 7; i++)
            do_read(vecs[i].addr, vecs[i].din, vecs[i].hit, $sformatf("vec%0d", i));

        // Read issued while paused is parked and serviced after the ack.
        abort_session("abort1");
        pause_ack = 1'b0;
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        check("pend pause_req", 32'(pause_req), 32'd1);
        exp_q.push_back(8'hD3);
        ioctl_addr = 25'h010; ioctl_rd = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        @(negedge clk_sys);
        check("pend held off", 32'(ram_rd), 32'd0);
        pause_ack = 1'b1;
        cnt = 0;
        while (!ram_rd && cnt < 10) begin
            @(negedge clk_sys);
            cnt++;
        end
        check("pend ram_rd seen", 32'(ram_rd), 32'd1);
        check("pend ram_addr", 32'(ram_addr), 32'h010);
        exp_pulses++;
        repeat (2) @(negedge clk_sys);
        check("pend wait", 32'(ioctl_wait), 32'd0);
        check("pend din", 32'(ioctl_din), 32'((exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx));
        last_din = 8'hD3;

        // No ack at all: READY after 16 paused cycles, flag sticks.
        abort_session("abort2");
        pause_ack = 1'b0;
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        cnt = 0;
        while (ioctl_wait && cnt < 100) begin
            cnt++;
            @(negedge clk_sys);
        end
        check("timeout cycles", 32'(cnt), 32'd16);
        check("timeout flag", 32'(ack_timeout), 32'd1);
        do_read(25'h123, 8'hE0, 1'b1, "tmo read");
        check("timeout sticky", 32'(ack_timeout), 32'd1);
        abort_session("abort3");
        check("timeout kept idle", 32'(ack_timeout), 32'd1);
        pause_ack = 1'b1;
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        check("timeout cleared", 32'(ack_timeout), 32'd0);
        @(negedge clk_sys);

        // Upload drops while FETCH is in flight.
        ioctl_addr = 25'h005; ioctl_rd = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        check("fetch ram_rd", 32'(ram_rd), 32'd1);
        exp_pulses++;
        abort_session("abort fetch");
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        check("restart pause_req", 32'(pause_req), 32'd1);
        check("restart wait", 32'(ioctl_wait), 32'd1);
        @(negedge clk_sys);
        check("restart ready", 32'(ioctl_wait), 32'd0);
        do_read(25'h3FE, 8'h3D, 1'b1, "restart read");

        // Reset lands while CAPTURE is active.
        ioctl_addr = 25'h000; ioctl_rd = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        exp_pulses++;
        @(negedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        check_reset_vals("reset capture");
        ioctl_upload = 1'b0;
        reset = 1'b0;
        @(negedge clk_sys);
        check_reset_vals("post reset");

        check("ram_rd pulse count", 32'(pulses), 32'(exp_pulses));
        check("scoreboard empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1);
    end

endmodule
